// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - dual-slot instruction issue queue with enqueue-time predecode
// Circular buffer fed two fetch slots per cycle, issues up to two decoded-compatible instructions.
module instr_issue_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [1:0]                 in_valid_i,
  input  logic [63:0]                in_instr_i,
  input  logic [AW-1:0]              in_pc_i,
  output logic                       in_ready_o,
  input  logic                       out_ready_i,
  output logic [1:0]                 out_valid_o,
  output logic [63:0]                out_instr_o,
  output logic [2*AW-1:0]            out_pc_o,
  output logic [1:0]                 out_branch_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Returns {priv, mem, br} for one instruction word.
  function automatic logic [2:0] predecode(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    logic       br;
    logic       mem;
    logic       priv;
    op   = ins[31:26];
    fn   = ins[5:0];
    br   = (op >= 6'h01 && op <= 6'h07) || (op == 6'h00 && (fn == 6'h08 || fn == 6'h09));
    mem  = (op[5:4] == 2'b10);
    priv = (op == 6'h10) || (op == 6'h00 && (fn == 6'h0C || fn == 6'h0D));
    return {priv, mem, br};
  endfunction

  logic [31:0]    instr_q [DEPTH];
  logic [AW-1:0]  pc_q    [DEPTH];
  logic [DEPTH-1:0] br_q;
  logic [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0] priv_q;

  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;

  logic [PW-1:0]  head1;
  logic [PW-1:0]  tail1;
  logic           enq;
  logic [1:0]     enq_n;
  logic [1:0]     deq_n;
  logic           pair_ok;
  logic [2:0]     pd0;
  logic [2:0]     pd1;

  assign head1 = head + 1'b1;
  assign tail1 = tail + 1'b1;

  // Ready looks only at the registered count so fetch never depends on decode's handshake.
  assign in_ready_o = (count <= CW'(DEPTH - 2));
  assign enq        = in_ready_o && in_valid_i[0];
  assign enq_n      = enq ? (in_valid_i[1] ? 2'd2 : 2'd1) : 2'd0;

  assign pair_ok = !br_q[head] && !priv_q[head] && !br_q[head1] && !priv_q[head1] &&
                   !(mem_q[head] && mem_q[head1]);

  assign out_valid_o[0] = (count != '0);
  assign out_valid_o[1] = (count >= CW'(2)) && pair_ok;
  assign deq_n          = out_ready_i ? ({1'b0, out_valid_o[0]} + {1'b0, out_valid_o[1]}) : 2'd0;

  assign out_instr_o  = {instr_q[head1], instr_q[head]};
  assign out_pc_o     = {pc_q[head1], pc_q[head]};
  assign out_branch_o = {out_valid_o[1] & br_q[head1], out_valid_o[0] & br_q[head]};
  assign count_o      = count;

  assign pd0 = predecode(in_instr_i[31:0]);
  assign pd1 = predecode(in_instr_i[63:32]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_n);
      tail  <= tail + PW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

  // Entry payload carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (enq && !flush_i) begin
      instr_q[tail] <= in_instr_i[31:0];
      pc_q[tail]    <= in_pc_i;
      br_q[tail]    <= pd0[0];
      mem_q[tail]   <= pd0[1];
      priv_q[tail]  <= pd0[2];
      if (in_valid_i[1]) begin
        instr_q[tail1] <= in_instr_i[63:32];
        pc_q[tail1]    <= in_pc_i + AW'(4);
        br_q[tail1]    <= pd1[0];
        mem_q[tail1]   <= pd1[1];
        priv_q[tail1]  <= pd1[2];
      end
    end
  end

endmodule
